// File: rtl/pc_unit.sv
// Program counter for the single-cycle MIPS datapath: sequential, branch, jump,
// call/return through a circular return-address stack, and stall support.
module pc_unit #(
  parameter int WIDTH      = 32,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_ADDR = 0,
  parameter int INC        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_udf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc    = pc + WIDTH'(INC);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL_CNT);

  // When full, a call overwrites the oldest entry because ptr simply wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= WIDTH'(RESET_ADDR);
      ptr     <= '0;
      count   <= '0;
      ras_ovf <= 1'b0;
      ras_udf <= 1'b0;
    end else if (!stall) begin
      if (ret) begin
        if (count != '0) begin
          pc    <= ras[ptr - 1'b1];
          ptr   <= ptr - 1'b1;
          count <= count - 1'b1;
        end else begin
          pc      <= pc_inc;
          ras_udf <= 1'b1;
        end
      end else if (jump_en) begin
        if (call) begin
          ras[ptr] <= pc_inc;
          ptr      <= ptr + 1'b1;
          if (count == FULL_CNT)
            ras_ovf <= 1'b1;
          else
            count <= count + 1'b1;
        end
        pc <= jump_target;
      end else if (branch_en) begin
        pc <= pc_inc + branch_off;
      end else begin
        pc <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: a vector table for the basic flow plus
// hand-written sequences for RAS overflow/underflow, stall, wrap and reset.
module tb_pc_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, stall, branch_en, jump_en, call, ret;
  logic [W-1:0] branch_off, jump_target, pc;
  logic         ras_empty, ras_full, ras_ovf, ras_udf;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(W), .RAS_DEPTH(4), .RESET_ADDR(0), .INC(1)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_en(branch_en), .branch_off(branch_off),
    .jump_en(jump_en), .jump_target(jump_target),
    .call(call), .ret(ret), .pc(pc),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_udf(ras_udf)
  );

  // Expected flags are packed as {empty, full, ovf, udf}.
  typedef struct {
    logic         rst;
    logic         stl;
    logic         br;
    logic [W-1:0] off;
    logic         jmp;
    logic [W-1:0] tgt;
    logic         cal;
    logic         rt;
    logic [W-1:0] epc;
    logic [3:0]   eflags;
  } vec_t;

  vec_t vecs [16];

  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [W-1:0] off, input logic j,
                               input logic [W-1:0] t, input logic c,
                               input logic rt);
    reset       = r;
    stall       = s;
    branch_en   = b;
    branch_off  = off;
    jump_en     = j;
    jump_target = t;
    call        = c;
    ret         = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] epc,
                             input logic [3:0] ef);
    logic [3:0] af;
    af = {ras_empty, ras_full, ras_ovf, ras_udf};
    checkCount++;
    if (pc === epc && af === ef)
      passCount++;
    else
      $display("[TB] FAIL %s: got pc=%h flags=%b, expected pc=%h flags=%b",
               name, pc, af, epc, ef);
  endtask

  task automatic idle(input logic [W-1:0] epc, input logic [3:0] ef, input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput(name, epc, ef);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_off = '0;
    jump_en = 1'b0; jump_target = '0; call = 1'b0; ret = 1'b0;

    //          rst   stl   br    off            jmp   tgt          cal   rt    epc          flags
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       4'b1000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h1,       4'b1000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h2,       4'b1000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h3,       4'b1000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h4,       4'b1000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h5,       4'b1000};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFD, 1'b0, 32'h0,       1'b0, 1'b0, 32'h3,       4'b1000};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'hA,        1'b0, 32'h0,       1'b0, 1'b0, 32'hE,       4'b1000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10,      1'b0, 1'b0, 32'h10,      4'b1000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,      1'b1, 1'b0, 32'h40,      4'b0000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h41,      4'b0000};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h7,        1'b1, 32'h99,      1'b0, 1'b1, 32'h11,      4'b1000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h12,      4'b1001};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       4'b1000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b0, 32'h1,       4'b1000};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h5,        1'b1, 32'h80,      1'b0, 1'b0, 32'h80,      4'b1000};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].off,
                    vecs[i].jmp, vecs[i].tgt, vecs[i].cal, vecs[i].rt);
      checkOutput($sformatf("vec%0d", i), vecs[i].epc, vecs[i].eflags);
    end

    // Five nested calls into a 4-deep stack, then five returns.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("nest_reset", 32'h0, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, W'((i + 1) * 32'h100), 1'b1, 1'b0);
      checkOutput($sformatf("call%0d", i), W'((i + 1) * 32'h100),
                  {1'b0, (i >= 3) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("ret%0d", i), W'(32'h401 - i * 32'h100),
                  {(i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("ret_underflow", 32'h102, 4'b1011);

    // Stall with competing controls freezes pc and the stack.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("stall_reset", 32'h0, 4'b1000);
    idle(32'h1, 4'b1000, "stall_pre1");
    idle(32'h2, 4'b1000, "stall_pre2");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h20, 1'b1, 1'b0);
    checkOutput("stall_call", 32'h20, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h8, 1'b0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("stall%0d", i), 32'h20, 4'b0000);
    end
    idle(32'h21, 4'b0000, "stall_release");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("stall_ret", 32'h3, 4'b1000);

    // Wrap-around from all-ones, branch wrap, and reset beating a jump.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput("wrap_jump", 32'hFFFFFFFF, 4'b1000);
    idle(32'h0, 4'b1000, "wrap_seq");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("wrap_branch", 32'h0, 4'b1000);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h50, 1'b1, 1'b0);
    checkOutput("pre_reset_call", 32'h50, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h99, 1'b1, 1'b0);
    checkOutput("reset_vs_jump", 32'h0, 4'b1000);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("reset_cleared_ras", 32'h1, 4'b1001);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the single-cycle MIPS datapath; drives the word-addressed instruction memory address.
- Adds to the plain sequential/branch PC: configurable width, increment and reset vector, pipeline stall, absolute jump, call/return with a circular return-address stack (RAS), and sticky stack-error flags.

Parameters:
- WIDTH, 32, PC and offset/target width in bits.
- RAS_DEPTH, 4, number of RAS entries (power of two, >= 2).
- RESET_ADDR, 0, PC value loaded on reset.
- INC, 1, sequential increment (1 = word addressing, 4 = byte addressing).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS; all other control inputs ignored this cycle.
- branch_en  in  1  take relative branch (branch & zero from control/ALU).
- branch_off  in  WIDTH  signed branch offset, in units of PC addresses.
- jump_en  in  1  take absolute jump to jump_target.
- jump_target  in  WIDTH  absolute jump/call destination.
- call  in  1  with jump_en: push return address, then jump.
- ret  in  1  pop RAS top into PC.
- pc  out  WIDTH  current program counter (registered).
- ras_empty  out  1  RAS holds 0 valid entries.
- ras_full  out  1  RAS holds RAS_DEPTH valid entries.
- ras_ovf  out  1  sticky: push attempted while full.
- ras_udf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (synchronous, highest priority): pc = RESET_ADDR, RAS count = 0, write pointer = 0, ras_ovf = ras_udf = 0; ras_empty = 1, ras_full = 0. Reset asserted mid-operation discards any pending control input that cycle.
- Next-PC priority when not reset: stall > ret > jump_en (with or without call) > branch_en > sequential.
- stall=1: pc, RAS contents, count, pointer and flags unchanged.
- ret=1 and count>0: pc <= RAS[ptr-1]; ptr decrements (mod RAS_DEPTH); count decrements. jump_en/call/branch_en ignored.
- ret=1 and count==0: pc <= pc+INC; ras_udf <= 1; RAS unchanged.
- jump_en=1, call=0: pc <= jump_target.
- jump_en=1, call=1: RAS[ptr] <= pc+INC; ptr increments (mod RAS_DEPTH); pc <= jump_target. If count<RAS_DEPTH, count increments; else count stays at RAS_DEPTH, oldest entry is overwritten (circular), ras_ovf <= 1.
- call=1 with jump_en=0: call ignored (no push).
- branch_en=1: pc <= pc + INC + branch_off.
- Otherwise: pc <= pc + INC.
- Arithmetic: all sums modulo 2^WIDTH; wrap-around from all-ones is silent, no flag.
- Latency: control inputs sampled on edge N take effect in pc after edge N (one cycle); pc is never combinational from inputs.
- ras_empty = (count==0), ras_full = (count==RAS_DEPTH); both derived from registered count.
- ras_ovf/ras_udf clear only on reset.

Test Plan:
- Reset then 3 free-running cycles, INC=1 -> pc = 0,1,2,3; ras_empty=1, flags 0.
- At pc=5, branch_en=1, branch_off=-3 (0xFFFFFFFD) -> pc=3 next cycle; branch_off=+10 at pc=3 -> pc=14.
- At pc=0x10, jump_en=call=1, jump_target=0x40; two cycles later ret=1 -> pc: 0x40, 0x41, 0x11; ras_empty returns to 1.
- RAS_DEPTH=4: five nested calls from pcs 0x0,0x100,0x200,0x300,0x400 (targets 0x100..0x500) -> ras_full=1, ras_ovf=1; five rets yield 0x401,0x301,0x201,0x101, then pc+1 with ras_udf=1.
- stall=1 for 3 cycles with branch_en=1, ret=1 asserted -> pc and count frozen; after release, sequential resumes from held pc.
- pc=0xFFFFFFFF, no control -> pc=0x0; reset asserted in same cycle as jump_en -> pc=RESET_ADDR, RAS cleared.
